// File: rtl/gan_out_collector.sv
// Output collector for the 8-stage GAN pipeline: tags real samples through a
// latency-matched shift register, buffers 4-word frames and streams them out.
module gan_out_collector #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_start,
    input  logic [WIDTH-1:0] out1,
    input  logic [WIDTH-1:0] out2,
    input  logic [WIDTH-1:0] out3,
    input  logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       m_idx,
    output logic             m_last,
    input  logic             clr,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_CNT  = CW'(2);

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [4*WIDTH-1:0] frame_t;

    state_t           state_q;
    logic [LATENCY-1:0] tag_q;
    frame_t           fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] m_data_q;
    logic             m_valid_q;
    logic [1:0]       m_idx_q;
    logic             overflow_q;
    logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;

    logic   cap, pop, full, push, drop;
    frame_t head, next_head;

    // Word 0 (out1) lives in the most significant slice of a frame.
    function automatic logic [WIDTH-1:0] word_of(input frame_t f, input logic [1:0] i);
        return f[(3 - int'(i)) * WIDTH +: WIDTH];
    endfunction

    assign cap       = tag_q[LATENCY-1];
    assign pop       = m_valid_q & m_ready & (m_idx_q == 2'd3);
    assign full      = (count_q == FULL_CNT);
    assign drop      = cap & full & ~pop;
    assign push      = cap & ~drop;
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign head      = fifo_mem[rd_ptr_q];
    assign next_head = fifo_mem[rd_ptr_q + PW'(1)];

    // NOTE: non-blocking assignments so every stage shifts from its pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tag_q <= '0;
        else      tag_q <= {tag_q[LATENCY-2:0], in_start};
    end

    // NOTE: frame storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {out1, out2, out3, out4};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // A frame captured on the same edge as a pop waits in IDLE for one cycle,
    // so the next head is taken from storage only when it was already there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_idx_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q   <= SEND;
                        m_valid_q <= 1'b1;
                        m_idx_q   <= 2'd0;
                        m_data_q  <= word_of(head, 2'd0);
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (m_idx_q != 2'd3) begin
                            m_idx_q  <= m_idx_q + 2'd1;
                            m_data_q <= word_of(head, m_idx_q + 2'd1);
                        end else if (count_q >= TWO_CNT) begin
                            m_idx_q  <= 2'd0;
                            m_data_q <= word_of(next_head, 2'd0);
                        end else begin
                            state_q   <= IDLE;
                            m_valid_q <= 1'b0;
                            m_idx_q   <= 2'd0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // clr wins over any same-cycle drop or completed frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (clr) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            if (pop)  frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_idx     = m_idx_q;
    assign m_last    = m_valid_q & (m_idx_q == 2'd3);
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gan_out_collector.sv
// Self-checking bench for gan_out_collector: directed vector tables, corner
// sequences and a randomized run against a queue-based frame model.
module tb_gan_out_collector;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;

    typedef logic [3:0][WIDTH-1:0] frame_t;

    typedef struct {
        frame_t in_w;
        frame_t exp_w;
    } ss_vec_t;

    typedef struct {
        int n_starts;
        int exp_drop;
        int exp_ovf;
        int exp_frames;
    } ovf_vec_t;

    logic             clk = 1'b0, rst = 1'b1, in_start = 1'b0, m_ready = 1'b0, clr = 1'b0;
    logic [WIDTH-1:0] out1 = '0, out2 = '0, out3 = '0, out4 = '0;
    logic [WIDTH-1:0] m_data;
    logic             m_valid, m_last, overflow;
    logic [1:0]       m_idx;
    logic [CNT_W-1:0] frame_cnt, drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    gan_out_collector #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_start(in_start),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_last(m_last),
        .clr(clr), .overflow(overflow), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: pending capture times, a queue of frames, and the
    // position of the word currently offered downstream.
    frame_t           mdl_fifo[$];
    int unsigned      mdl_due[$];
    int unsigned      ncyc = 0;
    bit               mdl_valid = 1'b0;
    int               mdl_idx = 0;
    bit               mdl_ovf = 1'b0;
    logic [CNT_W-1:0] mdl_fcnt = '0, mdl_dcnt = '0;

    function automatic frame_t mk(input logic [WIDTH-1:0] a, b, c, d);
        frame_t f;
        f[0] = a; f[1] = b; f[2] = c; f[3] = d;
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_fifo.delete();
        mdl_due.delete();
        mdl_valid = 1'b0;
        mdl_idx   = 0;
        mdl_ovf   = 1'b0;
        mdl_fcnt  = '0;
        mdl_dcnt  = '0;
    endtask

    task automatic model_edge();
        bit hs, last, cap, drop;
        int n_before;
        ncyc++;
        cap = 1'b0;
        if (mdl_due.size() > 0 && mdl_due[0] == ncyc) begin
            cap = 1'b1;
            void'(mdl_due.pop_front());
        end
        if (in_start) mdl_due.push_back(ncyc + 32'(LATENCY));
        n_before = mdl_fifo.size();
        hs   = mdl_valid && m_ready;
        last = hs && (mdl_idx == 3);
        drop = cap && ((n_before - int'(last)) >= DEPTH);
        if (last) void'(mdl_fifo.pop_front());
        if (cap && !drop) mdl_fifo.push_back(mk(out1, out2, out3, out4));
        // Only frames stored before this edge may be offered after it.
        if (!mdl_valid) begin
            if (n_before > 0) begin
                mdl_valid = 1'b1;
                mdl_idx   = 0;
            end
        end else if (last) begin
            mdl_idx = 0;
            if (n_before - 1 == 0) mdl_valid = 1'b0;
        end else if (hs) begin
            mdl_idx++;
        end
        if (clr) begin
            mdl_ovf  = 1'b0;
            mdl_fcnt = '0;
            mdl_dcnt = '0;
        end else begin
            if (drop) mdl_ovf = 1'b1;
            if (last) mdl_fcnt++;
            if (drop && mdl_dcnt != '1) mdl_dcnt++;
        end
    endtask

    task automatic compare_all();
        check("m_valid", 64'(m_valid), 64'(mdl_valid));
        check("m_idx", 64'(m_idx), 64'(mdl_idx));
        check("m_last", 64'(m_last), 64'(mdl_valid && mdl_idx == 3));
        if (mdl_valid && mdl_fifo.size() > 0)
            check("m_data", 64'(m_data), 64'(mdl_fifo[0][mdl_idx]));
        check("overflow", 64'(overflow), 64'(mdl_ovf));
        check("frame_cnt", 64'(frame_cnt), 64'(mdl_fcnt));
        check("drop_cnt", 64'(drop_cnt), 64'(mdl_dcnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rcycle();
        out1 = $urandom(); out2 = $urandom(); out3 = $urandom(); out4 = $urandom();
        cycle();
    endtask

    task automatic wait_valid(input int max_cycles, output int t);
        t = 0;
        while (!m_valid && t < max_cycles) begin
            cycle();
            t++;
        end
        if (!m_valid) check("wait_valid timeout", 64'(m_valid), 64'(1));
    endtask

    task automatic drain_all(output int frames);
        bit done;
        frames   = 0;
        done     = 1'b0;
        m_ready  = 1'b1;
        in_start = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (m_valid && m_last) frames++;
            rcycle();
            done = !m_valid && mdl_fifo.size() == 0 && mdl_due.size() == 0;
        end
        if (!done) check("drain timeout", 64'(m_valid), 64'(0));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    ss_vec_t  ss_tab[3];
    ovf_vec_t ov_tab[5];

    initial begin
        int t, frames, run, seen;

        ss_tab[0] = '{in_w: mk(32'd5, 32'hFFFF_FFFD, 32'd7, 32'h7FFF_FFFF),
                      exp_w: mk(32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0007, 32'h7FFF_FFFF)};
        ss_tab[1] = '{in_w: mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1),
                      exp_w: mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001)};
        ss_tab[2] = '{in_w: mk(32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5, 32'h5A5A_5A5A),
                      exp_w: mk(32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5, 32'h5A5A_5A5A)};

        ov_tab[0] = '{n_starts: 1,  exp_drop: 0, exp_ovf: 0, exp_frames: 1};
        ov_tab[1] = '{n_starts: 4,  exp_drop: 0, exp_ovf: 0, exp_frames: 4};
        ov_tab[2] = '{n_starts: 5,  exp_drop: 1, exp_ovf: 1, exp_frames: 4};
        ov_tab[3] = '{n_starts: 6,  exp_drop: 2, exp_ovf: 1, exp_frames: 4};
        ov_tab[4] = '{n_starts: 10, exp_drop: 6, exp_ovf: 1, exp_frames: 4};

        // Power-on reset.
        #2 rst = 1'b0;
        model_reset();
        repeat (3) cycle();
        check("reset m_data", 64'(m_data), 64'(0));
        rst = 1'b1;
        cycle();

        // Single samples from the vector table.
        pulse_clr();
        for (int v = 0; v < 3; v++) begin
            out1 = ss_tab[v].in_w[0]; out2 = ss_tab[v].in_w[1];
            out3 = ss_tab[v].in_w[2]; out4 = ss_tab[v].in_w[3];
            m_ready  = 1'b1;
            in_start = 1'b1;
            cycle();
            in_start = 1'b0;
            wait_valid(40, t);
            check("ss latency", 64'(t), 64'(LATENCY + 1));
            for (int w = 0; w < 4; w++) begin
                check("ss data", 64'(m_data), 64'(ss_tab[v].exp_w[w]));
                check("ss idx", 64'(m_idx), 64'(w));
                check("ss last", 64'(m_last), 64'(w == 3));
                cycle();
            end
            check("ss frame_cnt", 64'(frame_cnt), 64'(v + 1));
            check("ss idle", 64'(m_valid), 64'(0));
        end

        // Back-to-back starts stream without a bubble.
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_start = 1'b1;
            rcycle();
        end
        in_start = 1'b0;
        wait_valid(40, t);
        run = 0;
        while (m_valid && run < 40) begin
            run++;
            rcycle();
        end
        check("b2b contiguous words", 64'(run), 64'(16));
        check("b2b frame_cnt", 64'(frame_cnt), 64'(7));

        // Backpressure at word index 2.
        out1 = 32'hA1A1_0001; out2 = 32'hB2B2_0002; out3 = 32'hC3C3_0003; out4 = 32'hD4D4_0004;
        in_start = 1'b1;
        cycle();
        in_start = 1'b0;
        wait_valid(40, t);
        t = 0;
        while (m_idx != 2'd2 && t < 10) begin
            cycle();
            t++;
        end
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("bp held data", 64'(m_data), 64'(32'hC3C3_0003));
            check("bp held idx", 64'(m_idx), 64'(2));
            check("bp held valid", 64'(m_valid), 64'(1));
            cycle();
        end
        m_ready = 1'b1;
        check("bp release data", 64'(m_data), 64'(32'hC3C3_0003));
        cycle();
        check("bp last data", 64'(m_data), 64'(32'hD4D4_0004));
        check("bp last flag", 64'(m_last), 64'(1));
        cycle();
        check("bp idle", 64'(m_valid), 64'(0));

        // Overflow scenarios from the table.
        for (int v = 0; v < 5; v++) begin
            pulse_clr();
            m_ready = 1'b0;
            for (int i = 0; i < ov_tab[v].n_starts; i++) begin
                in_start = 1'b1;
                rcycle();
            end
            in_start = 1'b0;
            repeat (LATENCY + 2) rcycle();
            check("ovf drop_cnt", 64'(drop_cnt), 64'(ov_tab[v].exp_drop));
            check("ovf flag", 64'(overflow), 64'(ov_tab[v].exp_ovf));
            drain_all(frames);
            check("ovf drained frames", 64'(frames), 64'(ov_tab[v].exp_frames));
            pulse_clr();
            check("clr overflow", 64'(overflow), 64'(0));
            check("clr frame_cnt", 64'(frame_cnt), 64'(0));
            check("clr drop_cnt", 64'(drop_cnt), 64'(0));
        end

        // Full FIFO: capture lands on the edge that pops the head's last word.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_start = 1'b1;
            rcycle();
        end
        in_start = 1'b0;
        repeat (LATENCY) rcycle();
        in_start = 1'b1;
        rcycle();
        in_start = 1'b0;
        m_ready  = 1'b1;
        repeat (3) rcycle();
        m_ready = 1'b0;
        repeat (4) rcycle();
        m_ready = 1'b1;
        check("bnd at last word", 64'(m_last), 64'(1));
        rcycle();
        check("bnd drop_cnt", 64'(drop_cnt), 64'(0));
        check("bnd overflow", 64'(overflow), 64'(0));
        drain_all(frames);
        check("bnd remaining frames", 64'(frames), 64'(4));
        check("bnd frame_cnt", 64'(frame_cnt), 64'(5));

        // Reset mid-frame with tags in flight.
        m_ready  = 1'b0;
        in_start = 1'b1;
        rcycle();
        in_start = 1'b0;
        wait_valid(40, t);
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        check("rst pre idx", 64'(m_idx), 64'(1));
        for (int i = 0; i < 3; i++) begin
            in_start = 1'b1;
            rcycle();
            in_start = 1'b0;
            rcycle();
        end
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst async m_valid", 64'(m_valid), 64'(0));
        check("rst async m_data", 64'(m_data), 64'(0));
        repeat (2) cycle();
        rst     = 1'b1;
        m_ready = 1'b1;
        seen    = 0;
        repeat (30) begin
            rcycle();
            if (m_valid) seen++;
        end
        check("rst no stale frames", 64'(seen), 64'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_start = ($urandom_range(3) == 0);
            m_ready  = (i < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            clr      = ($urandom_range(63) == 0);
            rcycle();
        end
        clr = 1'b0;
        drain_all(frames);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
